// File: rtl/ld_wb_arbiter.sv
// Load writeback arbiter: oldest-sqN grant onto the single load result port, registered output stage.
// Optional starvation counters with forced grant are built when LDWB_STARVE_EN is defined.
module ld_wb_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int STARVE_MAX = 7,
   parameter int SQN_W      = 7,
   parameter int RESULT_W   = 32,
   parameter int TAG_W      = 7,
   parameter int FLAGS_W    = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          IN_branch_taken,
   input  logic [SQN_W-1:0]              IN_branch_sqN,
   input  logic                          IN_portBusy,
   input  logic [NUM_REQ-1:0]            IN_req_valid,
   input  logic [NUM_REQ*RESULT_W-1:0]   IN_req_result,
   input  logic [NUM_REQ*TAG_W-1:0]      IN_req_tagDst,
   input  logic [NUM_REQ*SQN_W-1:0]      IN_req_sqN,
   input  logic [NUM_REQ*FLAGS_W-1:0]    IN_req_flags,
   input  logic [NUM_REQ-1:0]            IN_req_doNotCommit,
   output logic [NUM_REQ-1:0]            OUT_stall,
   output logic                          OUT_uop_valid,
   output logic [RESULT_W-1:0]           OUT_uop_result,
   output logic [TAG_W-1:0]              OUT_uop_tagDst,
   output logic [SQN_W-1:0]              OUT_uop_sqN,
   output logic [FLAGS_W-1:0]            OUT_uop_flags,
   output logic                          OUT_uop_doNotCommit
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   logic [SQN_W-1:0]   req_sqn  [NUM_REQ];
   logic [SQN_W-1:0]   br_diff  [NUM_REQ];
   logic [SQN_W-1:0]   age_diff;
   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] starved;
   logic [NUM_REQ-1:0] gnt_vec;
   logic               any_elig;
   logic               force_any;
   logic               grant_any;
   logic [IDX_W-1:0]   age_idx;
   logic [IDX_W-1:0]   force_idx;
   logic [IDX_W-1:0]   win_idx;

   logic                out_valid_q,  out_valid_d;
   logic [RESULT_W-1:0] out_result_q, out_result_d;
   logic [TAG_W-1:0]    out_tag_q,    out_tag_d;
   logic [SQN_W-1:0]    out_sqn_q,    out_sqn_d;
   logic [FLAGS_W-1:0]  out_flags_q,  out_flags_d;
   logic                out_dnc_q,    out_dnc_d;

   // Flushed = strictly younger than the branch, i.e. (sqN - branch sqN) signed > 0.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_sqn[i] = IN_req_sqN[i*SQN_W +: SQN_W];
         br_diff[i] = req_sqn[i] - IN_branch_sqN;
         elig[i]    = IN_req_valid[i] &&
                      !(IN_branch_taken && (br_diff[i] != '0) && !br_diff[i][SQN_W-1]);
      end
   end

   // Strict "older than" keeps the lower index on equal sqN.
   always_comb begin
      any_elig = 1'b0;
      age_idx  = '0;
      age_diff = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         age_diff = req_sqn[i] - req_sqn[age_idx];
         if (elig[i] && (!any_elig || age_diff[SQN_W-1])) begin
            age_idx  = IDX_W'(i);
            any_elig = 1'b1;
         end
      end
   end

   always_comb begin
      force_any = 1'b0;
      force_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (starved[i] && !force_any) begin
            force_any = 1'b1;
            force_idx = IDX_W'(i);
         end
      end
      win_idx   = force_any ? force_idx : age_idx;
      grant_any = rst && !IN_portBusy && any_elig;
      gnt_vec   = '0;
      if (grant_any) gnt_vec[win_idx] = 1'b1;
      OUT_stall = ~gnt_vec;
   end

`ifdef LDWB_STARVE_EN
   logic [CNT_W-1:0] starve_cnt_q [NUM_REQ];
   logic [CNT_W-1:0] starve_cnt_d [NUM_REQ];

   // Counters keep counting through port-busy cycles; saturation holds them at the forced-grant level.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         starved[i] = elig[i] && (starve_cnt_q[i] == CNT_W'(STARVE_MAX));
         if (!elig[i] || gnt_vec[i])
            starve_cnt_d[i] = '0;
         else if (starve_cnt_q[i] != CNT_W'(STARVE_MAX))
            starve_cnt_d[i] = starve_cnt_q[i] + 1'b1;
         else
            starve_cnt_d[i] = starve_cnt_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REQ; i++) starve_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) starve_cnt_q[i] <= starve_cnt_d[i];
      end
   end
`else
   logic unused_starve_max;

   always_comb begin
      starved           = '0;
      unused_starve_max = |CNT_W'(STARVE_MAX);
   end
`endif

   // The stage reloads every cycle, so a flushed output uop is dropped by the reload itself;
   // input flush filtering guarantees a new grant is never younger than the branch.
   always_comb begin
      out_valid_d  = grant_any;
      out_result_d = out_result_q;
      out_tag_d    = out_tag_q;
      out_sqn_d    = out_sqn_q;
      out_flags_d  = out_flags_q;
      out_dnc_d    = out_dnc_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_vec[i]) begin
            out_result_d = IN_req_result[i*RESULT_W +: RESULT_W];
            out_tag_d    = IN_req_tagDst[i*TAG_W +: TAG_W];
            out_sqn_d    = req_sqn[i];
            out_flags_d  = IN_req_flags[i*FLAGS_W +: FLAGS_W];
            out_dnc_d    = IN_req_doNotCommit[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_tag_q    <= '0;
         out_sqn_q    <= '0;
         out_flags_q  <= '0;
         out_dnc_q    <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_tag_q    <= out_tag_d;
         out_sqn_q    <= out_sqn_d;
         out_flags_q  <= out_flags_d;
         out_dnc_q    <= out_dnc_d;
      end
   end

   assign OUT_uop_valid       = out_valid_q;
   assign OUT_uop_result      = out_result_q;
   assign OUT_uop_tagDst      = out_tag_q;
   assign OUT_uop_sqN         = out_sqn_q;
   assign OUT_uop_flags       = out_flags_q;
   assign OUT_uop_doNotCommit = out_dnc_q;

endmodule

// File: tb/tb_ld_wb_arbiter.sv
// Directed bench for ld_wb_arbiter: vector table plus reset, port-busy, output-flush and starvation sequences.
module tb_ld_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        br_taken;
   logic [6:0]  br_sqn;
   logic        port_busy;
   logic [2:0]  req_valid;
   logic [95:0] req_result;
   logic [20:0] req_tag;
   logic [20:0] req_sqn;
   logic [11:0] req_flags;
   logic [2:0]  req_dnc;
   logic [2:0]  stall;
   logic        o_valid;
   logic [31:0] o_result;
   logic [6:0]  o_tag;
   logic [6:0]  o_sqn;
   logic [3:0]  o_flags;
   logic        o_dnc;

   int checks = 0;
   int errors = 0;
   logic [6:0] cur_sqn [3];

   ld_wb_arbiter dut (
      .clk(clk), .rst(rst),
      .IN_branch_taken(br_taken), .IN_branch_sqN(br_sqn),
      .IN_portBusy(port_busy),
      .IN_req_valid(req_valid), .IN_req_result(req_result), .IN_req_tagDst(req_tag),
      .IN_req_sqN(req_sqn), .IN_req_flags(req_flags), .IN_req_doNotCommit(req_dnc),
      .OUT_stall(stall),
      .OUT_uop_valid(o_valid), .OUT_uop_result(o_result), .OUT_uop_tagDst(o_tag),
      .OUT_uop_sqN(o_sqn), .OUT_uop_flags(o_flags), .OUT_uop_doNotCommit(o_dnc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [43:0] payload_of(int i, logic [6:0] s);
      logic [31:0] r;
      logic [6:0]  t;
      logic [3:0]  f;
      logic        d;
      r = 32'h5A00 + (32'(i) << 24) + 32'(s);
      t = 7'(i * 3) + s;
      f = s[3:0] ^ 4'(i + 1);
      d = s[0] ^ i[0];
      return {r, t, f, d};
   endfunction

   task automatic drive(input logic [2:0] v, input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic tk, input logic [6:0] bs, input logic busy);
      logic [43:0] p;
      cur_sqn[0] = s0; cur_sqn[1] = s1; cur_sqn[2] = s2;
      req_valid = v; br_taken = tk; br_sqn = bs; port_busy = busy;
      for (int i = 0; i < 3; i++) begin
         p = payload_of(i, cur_sqn[i]);
         req_result[i*32 +: 32] = p[43:12];
         req_tag[i*7 +: 7]      = p[11:5];
         req_sqn[i*7 +: 7]      = cur_sqn[i];
         req_flags[i*4 +: 4]    = p[4:1];
         req_dnc[i]             = p[0];
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle with inputs already driven: stall checked mid-cycle, output checked after the edge.
   task automatic cycle(input string name, input int exp_idx);
      logic [2:0] exp_stall;
      exp_stall = 3'b111;
      if (exp_idx >= 0) exp_stall[exp_idx] = 1'b0;
      #2;
      check({name, " stall"}, 64'(stall), 64'(exp_stall));
      @(posedge clk);
      #1;
      check({name, " out_valid"}, 64'(o_valid), 64'(exp_idx >= 0));
      if (exp_idx >= 0) begin
         check({name, " out_sqn"}, 64'(o_sqn), 64'(cur_sqn[exp_idx]));
         check({name, " payload"}, 64'({o_result, o_tag, o_flags, o_dnc}),
               64'(payload_of(exp_idx, cur_sqn[exp_idx])));
      end
   endtask

   task automatic idle();
      drive(3'b000, 7'd0, 7'd0, 7'd0, 1'b0, 7'd0, 1'b0);
      cycle("idle", -1);
   endtask

   // req2 waits at sqN 50 while req0 keeps winning with older sqNs; nb busy cycles follow the 7 losses.
   task automatic starve_run(input int nb);
      int exp;
      for (int k = 1; k <= 8 + nb; k++) begin
         drive(3'b101, 7'(10 + k), 7'd0, 7'd50, 1'b0, 7'd0, (k > 7) && (k <= 7 + nb));
         if (k <= 7) exp = 0;
         else if (k <= 7 + nb) exp = -1;
         else begin
`ifdef LDWB_STARVE_EN
            exp = 2;
`else
            exp = 0;
`endif
         end
         cycle($sformatf("starve nb%0d k%0d", nb, k), exp);
      end
      idle();
   endtask

   typedef struct {
      string      name;
      logic [2:0] v;
      logic [6:0] s0, s1, s2;
      logic       tk;
      logic [6:0] bs;
      logic       busy;
      int         exp_idx;
   } vec_t;

   vec_t vecs [11];

   initial begin
      vecs[0]  = '{"age",          3'b111, 7'd5,   7'd3,   7'd3,   1'b0, 7'd0,   1'b0,  1};
      vecs[1]  = '{"wrap",         3'b011, 7'd126, 7'd1,   7'd0,   1'b0, 7'd0,   1'b0,  0};
      vecs[2]  = '{"flush_in",     3'b011, 7'd12,  7'd8,   7'd0,   1'b1, 7'd10,  1'b0,  1};
      vecs[3]  = '{"all_flushed",  3'b111, 7'd12,  7'd11,  7'd13,  1'b1, 7'd10,  1'b0, -1};
      vecs[4]  = '{"busy",         3'b001, 7'd4,   7'd0,   7'd0,   1'b0, 7'd0,   1'b1, -1};
      vecs[5]  = '{"none",         3'b000, 7'd1,   7'd2,   7'd3,   1'b0, 7'd0,   1'b0, -1};
      vecs[6]  = '{"only2",        3'b100, 7'd0,   7'd0,   7'd20,  1'b0, 7'd0,   1'b0,  2};
      vecs[7]  = '{"tie_all",      3'b111, 7'd9,   7'd9,   7'd9,   1'b0, 7'd0,   1'b0,  0};
      vecs[8]  = '{"wrap12",       3'b110, 7'd0,   7'd127, 7'd2,   1'b0, 7'd0,   1'b0,  1};
      vecs[9]  = '{"flush_equal",  3'b111, 7'd101, 7'd100, 7'd99,  1'b1, 7'd100, 1'b0,  2};
      vecs[10] = '{"flush_wrap",   3'b011, 7'd1,   7'd120, 7'd0,   1'b1, 7'd126, 1'b0,  1};

      rst = 1'b0;
      drive(3'b111, 7'd5, 7'd3, 7'd3, 1'b0, 7'd0, 1'b0);
      #2;
      check("reset stall", 64'(stall), 64'(3'b111));
      @(posedge clk);
      #1;
      check("reset out_valid", 64'(o_valid), 64'd0);
      rst = 1'b1;
      cycle("post_reset", 1);

      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].v, vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].tk, vecs[i].bs, vecs[i].busy);
         cycle(vecs[i].name, vecs[i].exp_idx);
         idle();
      end

      drive(3'b001, 7'd12, 7'd0, 7'd0, 1'b0, 7'd0, 1'b0);
      cycle("out_load12", 0);
      drive(3'b000, 7'd0, 7'd0, 7'd0, 1'b1, 7'd10, 1'b0);
      cycle("out_flush", -1);

      for (int k = 0; k < 3; k++) begin
         drive(3'b001, 7'd7, 7'd0, 7'd0, 1'b0, 7'd0, 1'b1);
         cycle($sformatf("portbusy%0d", k), -1);
      end
      drive(3'b001, 7'd7, 7'd0, 7'd0, 1'b0, 7'd0, 1'b0);
      cycle("portfree", 0);
      idle();

      starve_run(0);
      starve_run(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation ran past 50000 time units");
      $fatal(1);
   end

endmodule
